// File: rtl/uart_tx.sv
// Serialises one word per frame: start bit, DATA_W bits LSB first, optional parity, stop bit(s).
// Start bit drives one cycle after accept; tx_ready_o stays low for the whole frame and returns in the tx_done_o cycle.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_dout_o,
    output logic              tx_busy_o,
    output logic              tx_done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cyc_cnt, cyc_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              par_bit, par_nxt;
    logic              dout_nxt, done_nxt;
    logic              accept, bit_end;

    assign tx_ready_o = (state == IDLE);
    assign tx_busy_o  = (state != IDLE);
    assign accept     = tx_valid_i && tx_ready_o;
    assign bit_end    = (cyc_cnt == CYC_LAST);

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        done_nxt  = 1'b0;
        dout_nxt  = 1'b1;

        if (state != IDLE) begin
            cyc_nxt = bit_end ? '0 : cyc_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    shreg_nxt = tx_data_i;
                    // parity is fixed at accept so the shifting register need not be preserved
                    par_nxt   = (^tx_data_i) ^ (PARITY_ODD != 0);
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    bit_nxt   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // line is registered, so it is derived from where the FSM is going
        case (state_nxt)
            START:   dout_nxt = 1'b0;
            DATA:    dout_nxt = shreg_nxt[0];
            PARITY:  dout_nxt = par_nxt;
            default: dout_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tx_dout_o <= 1'b1;
            tx_done_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            cyc_cnt   <= cyc_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            par_bit   <= par_nxt;
            tx_dout_o <= dout_nxt;
            tx_done_o <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Four uart_tx configurations driven together; a frame-level model predicts every output each cycle.
module tb_uart_tx;

    localparam int MAXC = 8192;

    logic       clk;
    logic       rst;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic [3:0] rdy, dout, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1 cpb4   1: 8E1 cpb4   2: 8O1 cpb5   3: 7N2 cpb3
    uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .reset_i(rst), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
        .tx_ready_o(rdy[0]), .tx_dout_o(dout[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk_i(clk), .reset_i(rst), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
        .tx_ready_o(rdy[1]), .tx_dout_o(dout[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]));
    uart_tx #(.CLKS_PER_BIT(5), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk_i(clk), .reset_i(rst), .tx_data_i(data[2]), .tx_valid_i(valid[2]),
        .tx_ready_o(rdy[2]), .tx_dout_o(dout[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]));
    uart_tx #(.CLKS_PER_BIT(3), .DATA_W(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk_i(clk), .reset_i(rst), .tx_data_i(data[3][6:0]), .tx_valid_i(valid[3]),
        .tx_ready_o(rdy[3]), .tx_dout_o(dout[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]));

    function automatic int cpb_of(int d); return (d == 2) ? 5 : (d == 3) ? 3 : 4; endfunction
    function automatic int w_of(int d);   return (d == 3) ? 7 : 8; endfunction
    function automatic int pe_of(int d);  return (d == 1 || d == 2) ? 1 : 0; endfunction
    function automatic int po_of(int d);  return (d == 2) ? 1 : 0; endfunction
    function automatic int sb_of(int d);  return (d == 3) ? 2 : 1; endfunction
    function automatic int len_of(int d); return 1 + w_of(d) + pe_of(d) + sb_of(d); endfunction

    // frame as a list of line levels, index 0 = start bit
    function automatic logic [15:0] frame_of(int d, logic [7:0] v);
        logic [15:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < w_of(d); i++) begin
            f[i + 1] = v[i];
            ones += int'(v[i]);
        end
        if (pe_of(d) != 0) f[w_of(d) + 1] = (((ones + po_of(d)) % 2) != 0);
        return f;
    endfunction

    // model: cycle index, and per configuration the cycle its current frame started
    int          cyc = 0;
    bit          fvld  [4];
    int          fst   [4];
    logic [15:0] fbits [4];

    function automatic bit m_busy(int d);
        return fvld[d] && ((cyc - fst[d]) < len_of(d) * cpb_of(d));
    endfunction
    function automatic bit m_done(int d);
        return fvld[d] && ((cyc - fst[d]) == len_of(d) * cpb_of(d));
    endfunction
    function automatic bit m_line(int d);
        if (!m_busy(d)) return 1'b1;
        return fbits[d][(cyc - fst[d]) / cpb_of(d)];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                fvld[d] <= 1'b0;
            end else if (valid[d] && !m_busy(d)) begin
                fvld[d]  <= 1'b1;
                fst[d]   <= cyc + 1;
                fbits[d] <= frame_of(d, data[d]);
            end
        end
    end

    logic h_line [4][MAXC];
    logic h_busy [4][MAXC];
    logic h_done [4][MAXC];

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc=%0d actual=%0d required=%0d", nm, d, cyc, act, exp);
        end
    endtask

    // advance one cycle and compare all outputs against the model mid-cycle
    task automatic step();
        @(negedge clk);
        if (cyc < MAXC) begin
            for (int d = 0; d < 4; d++) begin
                h_line[d][cyc] = dout[d];
                h_busy[d][cyc] = busy[d];
                h_done[d][cyc] = done[d];
            end
        end
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                chk("line",  d, int'(dout[d]), int'(m_line(d)));
                chk("busy",  d, int'(busy[d]), int'(m_busy(d)));
                chk("ready", d, int'(rdy[d]),  int'(!m_busy(d)));
                chk("done",  d, int'(done[d]), int'(m_done(d)));
            end
        end
    endtask

    task automatic hold_until_accept(input int d);
        int n;
        n = 0;
        while (!rdy[d] && n < 400) begin
            step();
            n++;
        end
        chk("accept_wait", d, int'(n < 400), 1);
        step();
    endtask

    task automatic send(input int d, input logic [7:0] v);
        data[d]  = v;
        valid[d] = 1'b1;
        hold_until_accept(d);
        valid[d] = 1'b0;
    endtask

    function automatic int find_fall(int d, int from);
        for (int t = (from < 1) ? 1 : from; t < cyc && t < MAXC; t++)
            if (h_line[d][t - 1] == 1'b1 && h_line[d][t] == 1'b0) return t;
        return -1;
    endfunction

    function automatic int first_done(int d, int from);
        for (int t = from; t < cyc && t < MAXC; t++)
            if (h_done[d][t] == 1'b1) return t;
        return -1;
    endfunction

    function automatic int count_done(int d, int a, int b);
        int c;
        c = 0;
        for (int t = a; t < b && t < cyc && t < MAXC; t++)
            if (h_done[d][t] == 1'b1) c++;
        return c;
    endfunction

    function automatic logic [9:0] sample10(int d, int f, int off);
        logic [9:0] s;
        for (int k = 0; k < 10; k++) s[k] = h_line[d][f + cpb_of(d) * k + off];
        return s;
    endfunction

    int m, f, f2, run, t;

    initial begin
        rst   = 1'b1;
        valid = '0;
        for (int d = 0; d < 4; d++) data[d] = 8'h00;
        #2;
        for (int d = 0; d < 4; d++) begin
            chk("rst_line",  d, int'(dout[d]), 1);
            chk("rst_busy",  d, int'(busy[d]), 0);
            chk("rst_ready", d, int'(rdy[d]),  1);
            chk("rst_done",  d, int'(done[d]), 0);
        end
        step();
        step();
        #2 rst = 1'b0;
        step();

        // basic 0xA5 on 8N1, with a rejected request mid-frame
        m = cyc;
        send(0, 8'hA5);
        repeat (10) step();
        data[0] = 8'hFF; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0; data[0] = 8'h12;
        repeat (45) step();
        f = find_fall(0, m);
        chk("a5_found", 0, int'(f >= 0), 1);
        if (f < 1) f = 1;
        chk("a5_bits_first", 0, int'(sample10(0, f, 0)), 10'h34A);
        chk("a5_bits_last",  0, int'(sample10(0, f, 3)), 10'h34A);
        chk("a5_done_at",    0, first_done(0, f) - f, 40);
        chk("a5_done_cnt",   0, count_done(0, f, f + 50), 1);

        // back-to-back 0x55 then 0x0F with valid held high
        m = cyc;
        data[0] = 8'h55; valid[0] = 1'b1;
        hold_until_accept(0);
        data[0] = 8'h0F;
        hold_until_accept(0);
        valid[0] = 1'b0;
        repeat (50) step();
        f = find_fall(0, m);
        if (f < 1) f = 1;
        f2 = find_fall(0, f + 40);
        chk("b2b_found", 0, int'(f2 >= 0), 1);
        if (f2 < 1) f2 = 1;
        chk("b2b_bits1", 0, int'(sample10(0, f, 2)), 10'h2AA);
        chk("b2b_bits2", 0, int'(sample10(0, f2, 2)), 10'h21E);
        run = 0;
        t = f2 - 1;
        while (t > 0 && h_line[0][t] == 1'b1) begin
            run++;
            t--;
        end
        chk("b2b_gap",      0, run, 5);
        chk("b2b_done_acc", 0, first_done(0, f), f2 - 1);
        chk("b2b_done_cnt", 0, count_done(0, f, f2 + 41), 2);

        // parity
        m = cyc;
        send(1, 8'h01);
        repeat (50) step();
        f = find_fall(1, m);
        if (f < 1) f = 1;
        chk("even_par_01", 1, int'(h_line[1][f + 38]), 1);
        chk("even_stop",   1, int'(h_line[1][f + 42]), 1);
        chk("even_done",   1, first_done(1, f) - f, 44);
        m = cyc;
        send(2, 8'h01);
        repeat (65) step();
        f = find_fall(2, m);
        if (f < 1) f = 1;
        chk("odd_par_01", 2, int'(h_line[2][f + 47]), 0);
        chk("odd_done",   2, first_done(2, f) - f, 55);
        m = cyc;
        send(1, 8'h00);
        repeat (50) step();
        f = find_fall(1, m);
        if (f < 1) f = 1;
        chk("even_par_00", 1, int'(h_line[1][f + 38]), 0);

        // 7 data bits, 2 stop bits
        m = cyc;
        send(3, 8'h7F);
        repeat (40) step();
        f = find_fall(3, m);
        if (f < 1) f = 1;
        chk("ext_start", 3, int'(h_line[3][f + 1]), 0);
        chk("ext_d6",    3, int'(h_line[3][f + 22]), 1);
        chk("ext_stop1", 3, int'(h_line[3][f + 24]), 1);
        chk("ext_stop2", 3, int'(h_line[3][f + 29]), 1);
        chk("ext_busy_last", 3, int'(h_busy[3][f + 29]), 1);
        chk("ext_busy_end",  3, int'(h_busy[3][f + 30]), 0);
        chk("ext_done",      3, first_done(3, f) - f, 30);

        // reset mid-DATA, then accept on the first edge after release
        send(0, 8'h00);
        repeat (12) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_line",  0, int'(dout[0]), 1);
        chk("midrst_busy",  0, int'(busy[0]), 0);
        chk("midrst_ready", 0, int'(rdy[0]),  1);
        data[0] = 8'hC3; valid[0] = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
        #1 chk("postrst_ready", 0, int'(rdy[0]), 1);
        step();
        valid[0] = 1'b0;
        chk("postrst_start", 0, int'(dout[0]), 0);
        chk("postrst_busy",  0, int'(busy[0]), 1);
        repeat (60) step();

        // random traffic on all four configurations
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 4; d++) begin
                valid[d] = ($urandom_range(0, 2) == 0);
                data[d]  = 8'($urandom_range(0, 255));
            end
            step();
        end
        valid = '0;
        repeat (80) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes bytes from the core or memory side onto a single asynchronous serial line. It is the transmit counterpart of the UART receive path: its `tx_dout_o` connects directly to a receiver's `rx_din_i`. Data is accepted through a valid/ready handshake and framed as start bit, data bits (LSB first), optional parity, and stop bits. Each bit is held for a fixed number of clock cycles.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434 — clock cycles per serial bit (50 MHz / 115200). Must be ≥ 2.
- `DATA_W`, 8 — data bits per frame. Legal values: 5–8.
- `PARITY_EN`, 0 — 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0 — 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1 — number of stop bits, 1 or 2.

Ports:
- `clk_i` input 1 — single clock; all state changes on its rising edge.
- `reset_i` input 1 — asynchronous, active-high reset.
- `tx_data_i` input `DATA_W` — word to transmit; sampled only on accept.
- `tx_valid_i` input 1 — requester has a word.
- `tx_ready_o` output 1 — block can accept a word.
- `tx_dout_o` output 1 — serial line, registered, idles high.
- `tx_busy_o` output 1 — a frame is in progress.
- `tx_done_o` output 1 — one-cycle pulse when the final stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Encoding is free.
- **Accept:** occurs on a rising edge where `tx_valid_i && tx_ready_o`.
  - `tx_ready_o` = (state == IDLE); it is combinational from the state register.
  - On accept, `tx_data_i` is latched into a shift register. Later changes to `tx_data_i` have no effect on the frame.
- **IDLE**
  - Line high, `tx_busy_o`=0.
  - On accept: go to START, clear bit counter and cycle counter.
- **START**
  - Line 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - Line = shift register bit 0; shift right after each bit.
  - After `DATA_W` bits: go to PARITY if `PARITY_EN`, otherwise go to STOP.
- **PARITY**
  - Line = XOR of the latched data, inverted when `PARITY_ODD`=1.
  - Held for one bit time, then go to STOP.
- **STOP**
  - Line 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - Then go to IDLE and assert `tx_done_o` for exactly that one cycle (the first IDLE cycle).
- **Counters**
  - Cycle counter: `$clog2(CLKS_PER_BIT)` bits; counts 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary.
  - Bit counter: `$clog2(DATA_W+1)` bits.
  - No counter overflows past its terminal value.
- `tx_busy_o` = (state != IDLE).
- `tx_valid_i` outside IDLE is ignored, with no queuing. The requester must hold `tx_valid_i` until it sees ready.

## Timing
- **Reset values** (immediate, asynchronous):
  - `tx_dout_o`=1, `tx_busy_o`=0, `tx_done_o`=0, `tx_ready_o`=1.
  - State IDLE, all counters 0.
- **Reset mid-frame:** the frame is abandoned and the line goes high immediately. After release, the block is in IDLE and accepts on the first rising edge.
- **Start latency:** accept at edge N → `tx_dout_o`=0 after edge N, so the start bit begins in the cycle following the accept.
- **Bit width:** every bit is exactly `CLKS_PER_BIT` cycles (stop bits `CLKS_PER_BIT` each).
- **Frame length:** `CLKS_PER_BIT`×(1+`DATA_W`+`PARITY_EN`+`STOP_BITS`) cycles from the start bit to the end of the last stop bit.
- **Back-to-back:** with `tx_valid_i` held high, the next accept occurs in the `tx_done_o` cycle. The minimum line-high gap between frames is therefore `STOP_BITS`×`CLKS_PER_BIT`+1 cycles.
- **Simultaneous events:** `tx_done_o` and a new accept in the same cycle is legal; `tx_done_o` still pulses.

## Test plan
- **Reset:** assert `reset_i` mid-DATA → `tx_dout_o`=1 and `tx_busy_o`=0 before the next clock edge; after release, `tx_ready_o`=1.
- **Basic frame:** `CLKS_PER_BIT`=4, 8N1, send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. `tx_done_o` pulses once, 40 cycles after the start bit begins.
- **Parity:** `PARITY_EN`=1, send 0x01 → parity bit 1 when `PARITY_ODD`=0 and 0 when `PARITY_ODD`=1. Send 0x00 with even parity → parity bit 0.
- **Back-to-back:** hold `tx_valid_i` high with 0x55 then 0x0F → both frames are correct, line-high gap between them is exactly `CLKS_PER_BIT`+1 cycles, and there are two `tx_done_o` pulses.
- **Busy behaviour:** pulse `tx_valid_i` and change `tx_data_i` during DATA → no accept occurs and the frame in flight is unchanged.
- **Extended frame:** `STOP_BITS`=2, `DATA_W`=7, send 0x7F → stop bits last 2×`CLKS_PER_BIT` cycles and the total frame is 10×`CLKS_PER_BIT` cycles.
